button_debouncer: RTL and testbench

Debounces one raw mechanical push-button input (paddle up/down, serve, pause) for the Pong design.
- Synchronises the input to CLOCK.
- Emits a clean, registered level that is stable for at least STABLE_COUNT cycles.
- Sits directly upstream of the clocked positive one-shot: DebouncedOut drives the one-shot's InputPulse, so each physical press yields exactly one OneShot pulse.

---
 rtl/button_debouncer.sv | 140 ++++++++++++++
 tb/tb_button_debouncer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Two-flop synchronised, counter-timed push-button debouncer with registered level and settling flag.
// Optional BUTTON_PRESS_COUNT_EN adds an 8-bit wrapping count of committed presses (PressCount).
module button_debouncer #(
    parameter int unsigned STABLE_COUNT = 250000,
    parameter int unsigned CNT_W        = 18
) (
    input  logic       CLOCK,
    input  logic       Reset,
    input  logic       ButtonIn,
    output logic       DebouncedOut,
    output logic       Settling
`ifdef BUTTON_PRESS_COUNT_EN
    ,
    output logic [7:0] PressCount
`endif
);

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b10,
        CHECK_LOW   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LIMIT = CNT_W'(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             debounced_q;
    logic             debounced_d;
    logic             settling_q;
    logic             settling_d;

    // Next-state and counter; a reversal of sync2 mid-check returns to the committed level.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE_LOW: begin
                if (sync2_q) begin
                    state_d = CHECK_HIGH;
                    count_d = CNT_ONE;
                end else begin
                    count_d = '0;
                end
            end
            CHECK_HIGH: begin
                if (!sync2_q) begin
                    state_d = IDLE_LOW;
                    count_d = '0;
                end else if (count_q == STABLE_LIMIT) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync2_q) begin
                    state_d = CHECK_LOW;
                    count_d = CNT_ONE;
                end else begin
                    count_d = '0;
                end
            end
            CHECK_LOW: begin
                if (sync2_q) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                end else if (count_q == STABLE_LIMIT) begin
                    state_d = IDLE_LOW;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                count_d = '0;
            end
        endcase
        debounced_d = (state_d == STABLE_HIGH) || (state_d == CHECK_LOW);
        settling_d  = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
    end

    // Synchroniser, FSM state, counter and registered outputs.
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE_LOW;
            count_q     <= '0;
            debounced_q <= 1'b0;
            settling_q  <= 1'b0;
        end else begin
            sync1_q     <= ButtonIn;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            count_q     <= count_d;
            debounced_q <= debounced_d;
            settling_q  <= settling_d;
        end
    end

    assign DebouncedOut = debounced_q;
    assign Settling     = settling_q;

`ifdef BUTTON_PRESS_COUNT_EN
    logic       press_inc_s;
    logic [7:0] press_count_q;
    logic [7:0] press_count_d;

    // A press counts on the same edge the debounced level rises; 8-bit wrap is intended.
    always_comb begin
        press_inc_s = (state_q == CHECK_HIGH) && (state_d == STABLE_HIGH);
        if (press_inc_s) begin
            press_count_d = press_count_q + 8'd1;
        end else begin
            press_count_d = press_count_q;
        end
    end

    // Press counter register.
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            press_count_q <= 8'd0;
        end else begin
            press_count_q <= press_count_d;
        end
    end

    assign PressCount = press_count_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench: directed scenarios plus randomized bouncing against a run-length reference model.
module tb_button_debouncer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn   = 1'b0;
    logic deb0, set0, deb1, set1;
`ifdef BUTTON_PRESS_COUNT_EN
    logic [7:0] pc0, pc1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: index 0 -> STABLE_COUNT 4, index 1 -> STABLE_COUNT 1.
    bit m_s1  [2];
    bit m_s2  [2];
    bit m_com [2];
    int m_run [2];
    int m_pc  [2];

    always #5 clk = ~clk;

    button_debouncer #(.STABLE_COUNT(4), .CNT_W(18)) dut0 (
        .CLOCK(clk), .Reset(rst_n), .ButtonIn(btn), .DebouncedOut(deb0), .Settling(set0)
`ifdef BUTTON_PRESS_COUNT_EN
        , .PressCount(pc0)
`endif
    );

    button_debouncer #(.STABLE_COUNT(1), .CNT_W(18)) dut1 (
        .CLOCK(clk), .Reset(rst_n), .ButtonIn(btn), .DebouncedOut(deb1), .Settling(set1)
`ifdef BUTTON_PRESS_COUNT_EN
        , .PressCount(pc1)
`endif
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_com[i] = 1'b0; m_run[i] = 0; m_pc[i] = 0;
        end
    endtask

    // A new level commits after it has been seen on STABLE_COUNT+1 consecutive synchronised samples.
    task automatic model_edge();
        int sc;
        for (int i = 0; i < 2; i++) begin
            sc = (i == 0) ? 4 : 1;
            if (m_s2[i] != m_com[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == sc + 1) begin
                    m_com[i] = ~m_com[i];
                    m_run[i] = 0;
                    if (m_com[i]) m_pc[i] = m_pc[i] + 1;
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = btn;
        end
    endtask

    task automatic tick(input bit b);
        btn = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (deb0 !== 1'b0 || set0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got deb=%b set=%b exp deb=0 set=0", deb0, set0);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1);
            checks++;
            if (deb0 !== (e >= 7) || set0 !== (e >= 3 && e <= 6)) begin
                errors++;
                $display("FAIL reset_release edge %0d got deb=%b set=%b exp deb=%b set=%b",
                         e, deb0, set0, (e >= 7), (e >= 3 && e <= 6));
            end
        end
    endtask

    task automatic test_rise();
        apply_reset();
        tick(1'b0);
        tick(1'b0);
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1);
            checks++;
            if (deb0 !== (e >= 7) || set0 !== (e >= 3 && e <= 6)) begin
                errors++;
                $display("FAIL rise edge %0d got deb=%b set=%b exp deb=%b set=%b",
                         e, deb0, set0, (e >= 7), (e >= 3 && e <= 6));
            end
            checks++;
            if (deb1 !== (e >= 4) || set1 !== (e == 3)) begin
                errors++;
                $display("FAIL rise_sc1 edge %0d got deb=%b set=%b exp deb=%b set=%b",
                         e, deb1, set1, (e >= 4), (e == 3));
            end
        end
    endtask

    task automatic test_bounce();
        bit pat [8];
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            tick(pat[k]);
            checks++;
            if (deb0 !== 1'b0 || set0 !== (m_run[0] > 0) || deb1 !== m_com[1]) begin
                errors++;
                $display("FAIL bounce step %0d got deb=%b set=%b deb1=%b exp deb=0 set=%b deb1=%b",
                         k, deb0, set0, deb1, (m_run[0] > 0), m_com[1]);
            end
        end
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1);
            checks++;
            if (deb0 !== (e >= 7)) begin
                errors++;
                $display("FAIL bounce_final edge %0d got deb=%b exp %b", e, deb0, (e >= 7));
            end
        end
    endtask

    task automatic test_glitch_low();
        int settle_cnt = 0;
        tick(1'b1);
        tick(1'b1);
        for (int k = 0; k < 9; k++) begin
            tick((k < 3) ? 1'b0 : 1'b1);
            if (set0 === 1'b1) settle_cnt++;
            checks++;
            if (deb0 !== 1'b1) begin
                errors++;
                $display("FAIL glitch_low_deb step %0d got %b exp 1", k, deb0);
            end
        end
        checks++;
        if (settle_cnt != 3) begin
            errors++;
            $display("FAIL glitch_low_settle got %0d cycles exp 3", settle_cnt);
        end
    endtask

    task automatic test_reset_midcheck();
        apply_reset();
        repeat (4) tick(1'b1);
        checks++;
        if (set0 !== 1'b1 || deb0 !== 1'b0) begin
            errors++;
            $display("FAIL midcheck_pre got set=%b deb=%b exp set=1 deb=0", set0, deb0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (set0 !== 1'b0 || deb0 !== 1'b0) begin
            errors++;
            $display("FAIL midcheck_async got set=%b deb=%b exp set=0 deb=0", set0, deb0);
        end
        btn = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int last_toggle = -100;
        bit prev_deb    = 1'b0;
        bit lvl         = 1'b0;
        int hold        = 0;
        apply_reset();
        for (int c = 0; c < 1200; c++) begin
            if (hold == 0) begin
                lvl  = ~lvl;
                hold = (($urandom % 4) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(1, 6));
            end
            hold--;
            tick(lvl);
            checks++;
            if (deb0 !== m_com[0] || set0 !== (m_run[0] > 0) ||
                deb1 !== m_com[1] || set1 !== (m_run[1] > 0)) begin
                errors++;
                $display("FAIL random cycle %0d got %b%b%b%b exp %b%b%b%b", c, deb0, set0, deb1, set1,
                         m_com[0], (m_run[0] > 0), m_com[1], (m_run[1] > 0));
            end
`ifdef BUTTON_PRESS_COUNT_EN
            checks++;
            if (pc0 !== 8'(m_pc[0] % 256) || pc1 !== 8'(m_pc[1] % 256)) begin
                errors++;
                $display("FAIL random_count cycle %0d got %0d/%0d exp %0d/%0d", c, pc0, pc1,
                         m_pc[0] % 256, m_pc[1] % 256);
            end
`endif
            if (deb0 !== prev_deb) begin
                checks++;
                if (c - last_toggle < 5) begin
                    errors++;
                    $display("FAIL toggle_spacing cycle %0d got gap %0d exp >= 5", c, c - last_toggle);
                end
                last_toggle = c;
                prev_deb    = deb0;
            end
        end
    endtask

    task automatic test_presses();
        int rises    = 0;
        bit prev_deb = 1'b0;
        apply_reset();
        for (int p = 0; p < 257; p++) begin
            for (int k = 0; k < 20; k++) begin
                tick((k < 10) ? 1'b1 : 1'b0);
                if (deb0 === 1'b1 && prev_deb == 1'b0) rises++;
                prev_deb = deb0;
            end
        end
        checks++;
        if (rises != 257) begin
            errors++;
            $display("FAIL press_rises got %0d exp 257", rises);
        end
`ifdef BUTTON_PRESS_COUNT_EN
        checks++;
        if (pc0 !== 8'd1 || pc1 !== 8'd1) begin
            errors++;
            $display("FAIL press_count got %0d/%0d exp 1/1", pc0, pc1);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got no finish exp finish before limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rise();
        test_bounce();
        test_glitch_low();
        test_reset_midcheck();
        test_random();
        test_presses();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
